// File: rtl/dual_issue_dispatch.sv
// Dual-issue dispatch: in-order queue feeding the ID/EX register.
// Optional stat_dual/stat_bubble counters when DISPATCH_STATS_EN is defined.
//
// Ports: clk/reset (sync, active-high); in_* two-slot decode input with
// in_ready; ex_is_load/ex_rd load-use info from EX; ex_stall hold request;
// flush redirect; id_stall + out_* two-slot ID/EX writer side.
module dual_issue_dispatch #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       in_valid,
  output logic             in_ready,
  input  logic [1:0][31:0] in_pc,
  input  logic [1:0][31:0] in_rs1,
  input  logic [1:0][31:0] in_rs2,
  input  logic [1:0][31:0] in_imm,
  input  logic [1:0][4:0]  in_rd,
  input  logic [1:0][4:0]  in_rs1_idx,
  input  logic [1:0][4:0]  in_rs2_idx,
  input  logic [1:0][3:0]  in_alu_op,
  input  logic [1:0]       in_is_mem,
  input  logic [1:0]       in_is_store,
  input  logic [1:0]       ex_is_load,
  input  logic [1:0][4:0]  ex_rd,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             id_stall,
  output logic [1:0]       out_valid,
  output logic [1:0][31:0] out_pc,
  output logic [1:0][31:0] out_rs1,
  output logic [1:0][31:0] out_rs2,
  output logic [1:0][31:0] out_imm,
  output logic [1:0][4:0]  out_rd,
  output logic [1:0][3:0]  out_alu_op,
  output logic [1:0]       out_is_mem,
  output logic [1:0]       out_is_store
`ifdef DISPATCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_dual,
  output logic [CNT_W-1:0] stat_bubble
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [3:0]  alu_op;
    logic        is_mem;
    logic        is_store;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  entry_t     in_e [2];
  entry_t     ent_a, ent_b;
  entry_t     slot_a, slot_b;
  logic       kill;
  logic       haz_a, haz_b, raw_ab;
  logic       issue_a, issue_b;
  logic [1:0] push_n, pop_n;

  // Pointer add modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input logic [1:0]    n
  );
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(DEPTH))
      s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign id_stall = ex_stall;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      in_e[s].pc       = in_pc[s];
      in_e[s].rs1      = in_rs1[s];
      in_e[s].rs2      = in_rs2[s];
      in_e[s].imm      = in_imm[s];
      in_e[s].rd       = in_rd[s];
      in_e[s].rs1_idx  = in_rs1_idx[s];
      in_e[s].rs2_idx  = in_rs2_idx[s];
      in_e[s].alu_op   = in_alu_op[s];
      in_e[s].is_mem   = in_is_mem[s];
      in_e[s].is_store = in_is_store[s];
    end
  end

  always_comb begin
    kill  = flush | reset;
    ent_a = mem_q[head_q];
    ent_b = mem_q[wrap(head_q, 2'd1)];
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (ex_is_load[k] && ex_rd[k] != 5'd0) begin
        if (ex_rd[k] == ent_a.rs1_idx || ex_rd[k] == ent_a.rs2_idx)
          haz_a = 1'b1;
        if (ex_rd[k] == ent_b.rs1_idx || ex_rd[k] == ent_b.rs2_idx)
          haz_b = 1'b1;
      end
    end
    raw_ab = (ent_a.rd != 5'd0) &&
             (ent_a.rd == ent_b.rs1_idx || ent_a.rd == ent_b.rs2_idx);
    issue_a = !kill && (count_q >= CW'(1)) && !haz_a;
    issue_b = issue_a && (count_q >= CW'(2)) && !haz_b && !raw_ab &&
              !(ent_a.is_mem && ent_b.is_mem);
    slot_a = issue_a ? ent_a : '0;
    slot_b = issue_b ? ent_b : '0;
  end

  always_comb begin
    out_valid = {issue_b, issue_a};
    out_pc       = {slot_b.pc, slot_a.pc};
    out_rs1      = {slot_b.rs1, slot_a.rs1};
    out_rs2      = {slot_b.rs2, slot_a.rs2};
    out_imm      = {slot_b.imm, slot_a.imm};
    out_rd       = {slot_b.rd, slot_a.rd};
    out_alu_op   = {slot_b.alu_op, slot_a.alu_op};
    out_is_mem   = {slot_b.is_mem, slot_a.is_mem};
    out_is_store = {slot_b.is_store, slot_a.is_store};
  end

  always_comb begin
    push_n = 2'd0;
    if (in_ready && in_valid[0])
      push_n = in_valid[1] ? 2'd2 : 2'd1;
    pop_n = ex_stall ? 2'd0 : {1'b0, issue_a} + {1'b0, issue_b};
    mem_d = mem_q;
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_n != 2'd0)
        mem_d[tail_q] = in_e[0];
      if (push_n == 2'd2)
        mem_d[wrap(tail_q, 2'd1)] = in_e[1];
      head_d  = wrap(head_q, pop_n);
      tail_d  = wrap(tail_q, push_n);
      count_d = count_q - CW'(pop_n) + CW'(push_n);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] stat_dual_q, stat_dual_d;
  logic [CNT_W-1:0] stat_bubble_q, stat_bubble_d;

  always_comb begin
    stat_dual_d   = stat_dual_q;
    stat_bubble_d = stat_bubble_q;
    if (out_valid == 2'b11 && !ex_stall && !flush &&
        stat_dual_q != '1)
      stat_dual_d = stat_dual_q + CNT_W'(1);
    if (count_q != '0 && !out_valid[0] && !ex_stall &&
        stat_bubble_q != '1)
      stat_bubble_d = stat_bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_dual_q   <= '0;
      stat_bubble_q <= '0;
    end else begin
      stat_dual_q   <= stat_dual_d;
      stat_bubble_q <= stat_bubble_d;
    end
  end

  assign stat_dual   = stat_dual_q;
  assign stat_bubble = stat_bubble_q;
`endif

endmodule

// File: tb/tb_dual_issue_dispatch.sv
// Scoreboard bench for dual_issue_dispatch: directed pushes queue the
// expected issue groups, a negedge monitor pops and compares them.
module tb_dual_issue_dispatch;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       in_valid;
  logic             in_ready;
  logic [1:0][31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [1:0][4:0]  in_rd, in_rs1_idx, in_rs2_idx;
  logic [1:0][3:0]  in_alu_op;
  logic [1:0]       in_is_mem, in_is_store;
  logic [1:0]       ex_is_load;
  logic [1:0][4:0]  ex_rd;
  logic             ex_stall, flush;
  logic             id_stall;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_pc, out_rs1, out_rs2, out_imm;
  logic [1:0][4:0]  out_rd;
  logic [1:0][3:0]  out_alu_op;
  logic [1:0]       out_is_mem, out_is_store;
`ifdef DISPATCH_STATS_EN
  logic [15:0]      stat_dual, stat_bubble;
  logic [15:0]      dual_before;
`endif

  always #5 clk = ~clk;

  dual_issue_dispatch #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_rd(in_rd), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_alu_op(in_alu_op), .in_is_mem(in_is_mem),
    .in_is_store(in_is_store),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_rd(out_rd),
    .out_alu_op(out_alu_op), .out_is_mem(out_is_mem),
    .out_is_store(out_is_store)
`ifdef DISPATCH_STATS_EN
    , .stat_dual(stat_dual), .stat_bubble(stat_bubble)
`endif
  );

  typedef struct {
    logic [1:0]  v;
    logic [31:0] pc0, pc1;
    logic [4:0]  rd0, rd1;
    logic        m0, m1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Payload fields are derived from pc so the monitor can rebuild them.
  task automatic set_slot(input int s, input logic [31:0] pc,
                          input logic [4:0] rd, input logic [4:0] r1,
                          input logic [4:0] r2, input logic mem);
    in_pc[s]       = pc;
    in_rs1[s]      = pc + 32'd1;
    in_rs2[s]      = pc + 32'd2;
    in_imm[s]      = pc + 32'd3;
    in_rd[s]       = rd;
    in_rs1_idx[s]  = r1;
    in_rs2_idx[s]  = r2;
    in_alu_op[s]   = pc[5:2];
    in_is_mem[s]   = mem;
    in_is_store[s] = mem & pc[2];
  endtask

  task automatic expect_issue(input logic [1:0] v,
                              input logic [31:0] pc0, input logic [4:0] rd0,
                              input logic m0, input logic [31:0] pc1,
                              input logic [4:0] rd1, input logic m1);
    exp_t e;
    e.v = v; e.pc0 = pc0; e.rd0 = rd0; e.m0 = m0;
    e.pc1 = pc1; e.rd1 = rd1; e.m1 = m1;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && !flush && !ex_stall && out_valid != 2'b00) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_issue: got valid %b pc %h expected none",
                 out_valid, out_pc[0]);
      end else begin
        mon_e = sb.pop_front();
        chk("valid", {30'd0, out_valid}, {30'd0, mon_e.v});
        chk("pc0", out_pc[0], mon_e.pc0);
        chk("rd0", {27'd0, out_rd[0]}, {27'd0, mon_e.rd0});
        chk("rs1_0", out_rs1[0], mon_e.pc0 + 32'd1);
        chk("imm0", out_imm[0], mon_e.pc0 + 32'd3);
        chk("alu0", {28'd0, out_alu_op[0]}, {28'd0, mon_e.pc0[5:2]});
        chk("mem0", {31'd0, out_is_mem[0]}, {31'd0, mon_e.m0});
        chk("st0", {31'd0, out_is_store[0]},
            {31'd0, mon_e.m0 & mon_e.pc0[2]});
        if (mon_e.v[1]) begin
          chk("pc1", out_pc[1], mon_e.pc1);
          chk("rd1", {27'd0, out_rd[1]}, {27'd0, mon_e.rd1});
          chk("rs2_1", out_rs2[1], mon_e.pc1 + 32'd2);
          chk("mem1", {31'd0, out_is_mem[1]}, {31'd0, mon_e.m1});
        end else begin
          chk("bubble_pc1", out_pc[1], 32'd0);
          chk("bubble_rd1", {27'd0, out_rd[1]}, 32'd0);
          chk("bubble_alu1", {28'd0, out_alu_op[1]}, 32'd0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_valid = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    in_rd = '0; in_rs1_idx = '0; in_rs2_idx = '0; in_alu_op = '0;
    in_is_mem = '0; in_is_store = '0;
    ex_is_load = '0; ex_rd = '0; ex_stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    chk("rst_valid", {30'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_id_stall", {31'd0, id_stall}, 32'd0);
`ifdef DISPATCH_STATS_EN
    chk("rst_stat_dual", {16'd0, stat_dual}, 32'd0);
    chk("rst_stat_bubble", {16'd0, stat_bubble}, 32'd0);
`endif
    reset = 1'b0;

    // Independent ALU pair issues together.
    set_slot(0, 32'h100, 5'd5, 5'd1, 5'd2, 1'b0);
    set_slot(1, 32'h104, 5'd6, 5'd1, 5'd2, 1'b0);
    in_valid = 2'b11;
    expect_issue(2'b11, 32'h100, 5'd5, 1'b0, 32'h104, 5'd6, 1'b0);
    tick();
    in_valid = 2'b00;
    tick();
    chk("t1_ready", {31'd0, in_ready}, 32'd1);

    // Intra-pair RAW splits the pair.
    set_slot(0, 32'h200, 5'd7, 5'd1, 5'd2, 1'b0);
    set_slot(1, 32'h204, 5'd8, 5'd7, 5'd2, 1'b0);
    in_valid = 2'b11;
    expect_issue(2'b01, 32'h200, 5'd7, 1'b0, 32'h0, 5'd0, 1'b0);
    expect_issue(2'b01, 32'h204, 5'd8, 1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    in_valid = 2'b00;
    tick();
    tick();

    // Two memory ops share one port.
    set_slot(0, 32'h300, 5'd9, 5'd1, 5'd2, 1'b1);
    set_slot(1, 32'h304, 5'd10, 5'd3, 5'd4, 1'b1);
    in_valid = 2'b11;
    expect_issue(2'b01, 32'h300, 5'd9, 1'b1, 32'h0, 5'd0, 1'b0);
    expect_issue(2'b01, 32'h304, 5'd10, 1'b1, 32'h0, 5'd0, 1'b0);
    tick();
    in_valid = 2'b00;
    tick();
    tick();

    // Load-use on rs2; non-load EX slot with matching rd must not block.
    set_slot(0, 32'h400, 5'd11, 5'd1, 5'd3, 1'b0);
    in_valid = 2'b01;
    ex_is_load = 2'b01;
    ex_rd[0] = 5'd3;
    ex_rd[1] = 5'd1;
    expect_issue(2'b01, 32'h400, 5'd11, 1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    in_valid = 2'b00;
    #1;
    chk("lu_blocked", {30'd0, out_valid}, 32'd0);
    tick();
    ex_is_load = 2'b00;
    tick();
    ex_rd = '0;

    // Fill under ex_stall, then drain two per cycle.
    ex_stall = 1'b1;
    set_slot(0, 32'h500, 5'd12, 5'd1, 5'd2, 1'b0);
    set_slot(1, 32'h504, 5'd13, 5'd1, 5'd2, 1'b0);
    in_valid = 2'b11;
    expect_issue(2'b11, 32'h500, 5'd12, 1'b0, 32'h504, 5'd13, 1'b0);
    tick();
    chk("fill_ready2", {31'd0, in_ready}, 32'd1);
    set_slot(0, 32'h508, 5'd14, 5'd1, 5'd2, 1'b0);
    set_slot(1, 32'h50c, 5'd15, 5'd1, 5'd2, 1'b0);
    expect_issue(2'b11, 32'h508, 5'd14, 1'b0, 32'h50c, 5'd15, 1'b0);
    tick();
    in_valid = 2'b00;
    #1;
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    chk("full_id_stall", {31'd0, id_stall}, 32'd1);
    chk("full_head_pc", out_pc[0], 32'h500);
    tick();
    tick();
    ex_stall = 1'b0;
    tick();
    tick();
    chk("drain_ready", {31'd0, in_ready}, 32'd1);

    // Flush with three queued entries; flush-cycle input is dropped.
    ex_stall = 1'b1;
    set_slot(0, 32'h600, 5'd16, 5'd1, 5'd2, 1'b0);
    set_slot(1, 32'h604, 5'd17, 5'd1, 5'd2, 1'b0);
    in_valid = 2'b11;
    tick();
    set_slot(0, 32'h608, 5'd18, 5'd1, 5'd2, 1'b0);
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    #1;
    chk("cnt3_ready", {31'd0, in_ready}, 32'd0);
`ifdef DISPATCH_STATS_EN
    dual_before = stat_dual;
`endif
    ex_stall = 1'b0;
    flush = 1'b1;
    set_slot(0, 32'h700, 5'd19, 5'd1, 5'd2, 1'b0);
    set_slot(1, 32'h704, 5'd20, 5'd1, 5'd2, 1'b0);
    in_valid = 2'b11;
    #1;
    chk("flush_valid", {30'd0, out_valid}, 32'd0);
    chk("flush_pc0", out_pc[0], 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 2'b00;
    #1;
    chk("post_flush_ready", {31'd0, in_ready}, 32'd1);
    chk("post_flush_valid", {30'd0, out_valid}, 32'd0);
`ifdef DISPATCH_STATS_EN
    chk("flush_stat_dual", {16'd0, stat_dual}, {16'd0, dual_before});
`endif
    set_slot(0, 32'h800, 5'd21, 5'd1, 5'd2, 1'b0);
    in_valid = 2'b01;
    expect_issue(2'b01, 32'h800, 5'd21, 1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    in_valid = 2'b00;
    tick();

    // A.rd = x0 never forms a RAW dependence.
    set_slot(0, 32'h900, 5'd0, 5'd0, 5'd0, 1'b0);
    set_slot(1, 32'h904, 5'd22, 5'd0, 5'd0, 1'b0);
    in_valid = 2'b11;
    expect_issue(2'b11, 32'h900, 5'd0, 1'b0, 32'h904, 5'd22, 1'b0);
    tick();
    in_valid = 2'b00;
    tick();
    tick();

    chk("sb_drained", sb.size(), 32'd0);
`ifdef DISPATCH_STATS_EN
    chk("stat_dual_total", {16'd0, stat_dual}, 32'd4);
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dual_issue_dispatch.md
Name: dual_issue_dispatch

Overview:
- Issue stage of the dual-issue pipeline, placed between decode and the ID/EX register; it is the writer side of that register.
- Buffers decoded instructions in a small in-order queue.
- Each cycle, selects up to two instructions (oldest in slot 0) subject to pairing and load-use rules, and drives the ID/EX slot inputs and hold signal.
- Unissued slots are driven as bubbles.

Parameters:
- DEPTH, 4: queue entries. Must be even and at least 4.
- CNT_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  [1:0]  decode slot valid; slot 1 is ignored unless slot 0 is valid
- in_ready  out  1  queue can accept two entries this cycle
- in_pc, in_rs1, in_rs2, in_imm  in  32 x[1:0]  decoded operands per slot
- in_rd, in_rs1_idx, in_rs2_idx  in  5 x[1:0]  register indices per slot
- in_alu_op  in  4 x[1:0]  ALU opcode per slot
- in_is_mem, in_is_store  in  1 x[1:0]  memory-op flags per slot
- ex_is_load  in  1 x[1:0]  slot in EX holds a load
- ex_rd  in  5 x[1:0]  EX-stage destination per slot
- ex_stall  in  1  downstream hold request
- flush  in  1  branch redirect; discard all queued entries
- id_stall  out  1  hold for the ID/EX register; equals ex_stall
- out_valid  out  [1:0]  slot carries a real instruction
- out_pc, out_rs1, out_rs2, out_imm, out_rd, out_alu_op, out_is_mem, out_is_store  out  per-slot arrays matching the ID/EX register inputs
- stat_dual, stat_bubble  out  CNT_W  statistics counters (only when DISPATCH_STATS_EN is defined)

Behaviour:
- Storage:
  - Circular queue: head pointer, tail pointer, count (0..DEPTH).
  - All state is updated on the clk edge only.
- Reset:
  - count = head = tail = 0.
  - out_valid = 0; in_ready = 1; statistics counters = 0.
- Enqueue:
  - in_ready = (DEPTH - count_reg >= 2), computed from the registered count only.
  - Push count = in_valid[0] + (in_valid[0] & in_valid[1]), applied only when in_ready is high.
  - Slot 0 is written at tail, slot 1 at tail+1. Pointers wrap modulo DEPTH.
- Issue candidates:
  - A = head entry, valid if count >= 1.
  - B = head+1 entry, valid if count >= 2.
- Issue rules:
  - Load-use: if any ex_is_load[k] is set, ex_rd[k] != 0, and ex_rd[k] equals A.rs1_idx or A.rs2_idx, then nothing issues.
  - Otherwise A issues.
  - B issues only if all of the following hold:
    - A issues.
    - B passes the same load-use check.
    - No intra-pair RAW: A.rd == 0, or A.rd differs from both B.rs1_idx and B.rs2_idx.
    - Not both A.is_mem and B.is_mem (single memory port).
- Outputs:
  - Combinational from the queue head.
  - out_valid[0] = A issues; out_valid[1] = B issues.
  - A non-issued slot drives a bubble: all fields zero (rd = 0, alu_op = 0, is_mem = 0, is_store = 0).
- Pop:
  - Pop count = number of issued slots, forced to 0 when ex_stall = 1.
  - head advances by pop count.
  - New count = count - pop + push, all from one edge.
  - Simultaneous push and pop at full or empty is legal. Because in_ready is registered, overflow is impossible.
- ex_stall:
  - Queue state holds apart from enqueue; outputs still reflect the head.
  - id_stall = ex_stall, so the ID/EX register keeps its contents.
- flush:
  - Highest priority over push and pop.
  - Next cycle: count = head = tail = 0.
  - In the flush cycle itself, out_valid is forced to 0 and all fields are bubbles.
  - Input data presented in the flush cycle is dropped.
- reset asserted mid-operation: identical to flush, and the statistics counters also clear.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- When defined:
  - stat_dual increments on every cycle with out_valid = 2'b11, ex_stall = 0 and flush = 0.
  - stat_bubble increments on every cycle with count >= 1, out_valid[0] = 0 and ex_stall = 0.
  - Both counters saturate at all-ones.
- When undefined: the ports and counters are absent; zero extra logic.

Test Plan:
- Reset, then push two independent ALU ops (rd = 5, 6; sources x1, x2) -> next cycle out_valid = 11, count returns to 0.
- Pair A.rd = 7, B.rs1_idx = 7 -> cycle 1: out_valid = 01; cycle 2: B issues in slot 0 with out_valid = 01.
- Two loads queued -> issued on separate cycles, each with out_valid = 01.
- ex_is_load[0] = 1, ex_rd[0] = 3, head uses rs2_idx = 3 -> out_valid = 00 for that cycle; issues on the next cycle once the load clears.
- Fill to count = 4 while ex_stall = 1 -> in_ready = 0 and id_stall = 1; release ex_stall -> two entries pop per cycle.
- flush with count = 3 -> out_valid = 00 in the flush cycle; next cycle count = 0 and in_ready = 1. With DISPATCH_STATS_EN defined, stat_dual is unchanged by the flush cycle.
